// File: rtl/sms_pkg.sv
// Shared types and constants for the SMS cartridge download path.
package sms_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_HOLD,
        ST_WRITE,
        ST_FINISH
    } cart_loader_state_t;

    localparam logic [7:0] CODE_INDEX  = 8'hFF;
    localparam int         HDR_BYTES   = 512;
    localparam int         GG_IDX      = 2;
    localparam int         CART_ADDR_W = 22;
    localparam int         ROM_WADDR_W = 24;

endpackage

// File: rtl/cart_loader_if.sv
// HPS ioctl byte stream plus the SDRAM toggle write port seen by the cart loader.
// master = host side (HPS stream source, SDRAM ack), slave = the loader itself.
interface cart_loader_if #(
    parameter int WADDR_W = 24
);
    logic               ioctl_download;
    logic [7:0]         ioctl_index;
    logic               ioctl_wr;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic               ioctl_wait;

    logic               rom_wr;
    logic               rom_wack;
    logic [WADDR_W-1:0] romwr_a;
    logic [7:0]         rom_din;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_wack,
        input  ioctl_wait, rom_wr, romwr_a, rom_din
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, rom_wack,
        output ioctl_wait, rom_wr, romwr_a, rom_din
    );
endinterface

// File: rtl/cart_loader.sv
// Streams HPS cartridge bytes into SDRAM over a toggle req/ack pair, stalling the HPS
// per byte, and derives the cart address masks, copier-header flag and Game Gear flag.
module cart_loader #(
    parameter int ADDR_W    = sms_pkg::CART_ADDR_W,
    parameter int WADDR_W   = sms_pkg::ROM_WADDR_W,
    parameter int HDR_BYTES = sms_pkg::HDR_BYTES,
    parameter int GG_IDX    = sms_pkg::GG_IDX
) (
    input  logic              clk_sys,
    input  logic              reset,
    cart_loader_if.slave      bus,
    output logic              cart_download,
    output logic [ADDR_W-1:0] cart_mask,
    output logic [ADDR_W-1:0] cart_mask512,
    output logic              cart_sz512,
    output logic              gg,
    output logic              load_done,
    output logic              overrun
);
    import sms_pkg::*;

    localparam int                HDR_LOG2 = $clog2(HDR_BYTES);
    localparam logic [ADDR_W-1:0] HDR_A    = ADDR_W'(HDR_BYTES);
    localparam logic [4:0]        GG_IDX_5 = 5'(GG_IDX);

    cart_loader_state_t state_q;
    logic               cart_dl_q;
    logic               ioctl_wait_q;
    logic               rom_wr_q;
    logic [WADDR_W-1:0] romwr_a_q;
    logic [7:0]         rom_din_q;
    logic [ADDR_W-1:0]  cart_mask_q;
    logic [ADDR_W-1:0]  cart_mask512_q;
    logic [ADDR_W-1:0]  byte_count_q;
    logic               cart_sz512_q;
    logic               gg_q;
    logic               load_done_q;
    logic               overrun_q;

    logic [ADDR_W-1:0]  addr_d;
    logic               ack_match_d;
    logic               dl_rise_d;
    logic               wr_take_d;
    logic               toggle_d;
    logic               unused_addr_hi;

    assign cart_download  = bus.ioctl_download & (bus.ioctl_index != CODE_INDEX);
    assign addr_d         = bus.ioctl_addr[ADDR_W-1:0];
    assign unused_addr_hi = ^bus.ioctl_addr[24:ADDR_W];
    assign ack_match_d    = (rom_wr_q == bus.rom_wack);
    assign dl_rise_d      = cart_download & ~cart_dl_q;
    assign wr_take_d      = bus.ioctl_wr & cart_download;
    assign toggle_d       = ~reset & ack_match_d &
                            (((state_q == ST_ACCEPT) & wr_take_d) | (state_q == ST_HOLD));

    // The request toggle must stay in step with the SDRAM controller's ack, which
    // never sees our reset, so it is deliberately left out of the reset branch.
    always_ff @(posedge clk_sys) begin
        if (toggle_d) begin
            rom_wr_q <= ~rom_wr_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cart_dl_q      <= 1'b0;
            ioctl_wait_q   <= 1'b0;
            romwr_a_q      <= '0;
            rom_din_q      <= '0;
            cart_mask_q    <= '0;
            cart_mask512_q <= '0;
            byte_count_q   <= '0;
            cart_sz512_q   <= 1'b0;
            gg_q           <= 1'b0;
            load_done_q    <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            cart_dl_q   <= cart_download;
            load_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dl_rise_d) begin
                        romwr_a_q    <= '0;
                        byte_count_q <= '0;
                        overrun_q    <= 1'b0;
                        state_q      <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    if (wr_take_d) begin
                        rom_din_q    <= bus.ioctl_dout;
                        ioctl_wait_q <= 1'b1;
                        cart_mask_q  <= (addr_d == '0) ? '0 : (cart_mask_q | addr_d);
                        if (addr_d >= HDR_A) begin
                            cart_mask512_q <= (addr_d == HDR_A) ? '0
                                              : (cart_mask512_q | (addr_d - HDR_A));
                        end
                        gg_q    <= (bus.ioctl_index[4:0] == GG_IDX_5);
                        state_q <= ack_match_d ? ST_WRITE : ST_HOLD;
                    end else if (!cart_download) begin
                        state_q <= ST_FINISH;
                    end
                end
                ST_HOLD: begin
                    if (wr_take_d) begin
                        overrun_q <= 1'b1;
                    end
                    if (ack_match_d) begin
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wr_take_d) begin
                        overrun_q <= 1'b1;
                    end
                    if (ack_match_d) begin
                        ioctl_wait_q <= 1'b0;
                        romwr_a_q    <= romwr_a_q + WADDR_W'(1);
                        byte_count_q <= (&byte_count_q) ? byte_count_q
                                                        : byte_count_q + ADDR_W'(1);
                        state_q      <= cart_download ? ST_ACCEPT : ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    if (wr_take_d) begin
                        overrun_q <= 1'b1;
                    end
                    cart_sz512_q <= byte_count_q[HDR_LOG2];
                    load_done_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ioctl_wait = ioctl_wait_q;
    assign bus.rom_wr     = rom_wr_q;
    assign bus.romwr_a    = romwr_a_q;
    assign bus.rom_din    = rom_din_q;
    assign cart_mask      = cart_mask_q;
    assign cart_mask512   = cart_mask512_q;
    assign cart_sz512     = cart_sz512_q;
    assign gg             = gg_q;
    assign load_done      = load_done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_cart_loader.sv
// Directed bench for cart_loader: HPS byte driver, delayed-ack SDRAM model, event counters.
module tb_cart_loader;
    import sms_pkg::*;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    cart_loader_if #(.WADDR_W(ROM_WADDR_W)) bus ();

    logic                   cart_download;
    logic [CART_ADDR_W-1:0] cart_mask;
    logic [CART_ADDR_W-1:0] cart_mask512;
    logic                   cart_sz512;
    logic                   gg;
    logic                   load_done;
    logic                   overrun;

    cart_loader dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .bus           (bus.slave),
        .cart_download (cart_download),
        .cart_mask     (cart_mask),
        .cart_mask512  (cart_mask512),
        .cart_sz512    (cart_sz512),
        .gg            (gg),
        .load_done     (load_done),
        .overrun       (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // SDRAM side: acks a pending toggle ack_dly cycles after it becomes visible.
    int ack_dly = 3;
    int ack_cnt = 0;
    initial begin
        bus.rom_wack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (bus.rom_wr != bus.rom_wack) begin
                ack_cnt++;
                if (ack_cnt > ack_dly) begin
                    bus.rom_wack = bus.rom_wr;
                    ack_cnt      = 0;
                end
            end
        end
    end

    int         toggles     = 0;
    int         load_dones  = 0;
    int         wait_cycles = 0;
    int         din_changes = 0;
    logic       prev_wr     = 1'b0;
    logic       prev_busy   = 1'b0;
    logic [7:0] prev_din    = 8'h00;
    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if (bus.rom_wr != prev_wr) toggles++;
            if (load_done) load_dones++;
            if (bus.ioctl_wait) wait_cycles++;
            if (prev_busy && (bus.rom_wr != bus.rom_wack) && (bus.rom_din != prev_din))
                din_changes++;
            prev_wr   = bus.rom_wr;
            prev_busy = (bus.rom_wr != bus.rom_wack);
            prev_din  = bus.rom_din;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        @(negedge clk_sys);
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, output int tog_delta);
        int t0;
        int guard;
        t0             = toggles;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        bus.ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        tog_delta    = toggles - t0;
        guard        = 0;
        while (bus.ioctl_wait && guard < 200) begin
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 200) check_val("wait_timeout", 32'(guard), 32'd0);
    endtask

    task automatic run_image(input logic [7:0] idx, input int n, output int first_delta);
        int d;
        first_delta = 0;
        start_dl(idx);
        for (int i = 0; i < n; i++) begin
            send_byte(25'(i), 8'(i) ^ 8'h5A, d);
            if (i == 0) first_delta = d;
        end
        end_dl();
        $display("download idx=%0d bytes=%0d romwr_a=%0d mask=0x%0h mask512=0x%0h sz512=%0d gg=%0d",
                 idx, n, bus.romwr_a, cart_mask, cart_mask512, cart_sz512, gg);
    endtask

    initial begin
        int t_tog, t_ld, t_wait, t_din, d0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'h00;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = 8'h00;

        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        check_val("rst_wait",      32'(bus.ioctl_wait), 32'd0);
        check_val("rst_romwr_a",   32'(bus.romwr_a),    32'd0);
        check_val("rst_rom_din",   32'(bus.rom_din),    32'd0);
        check_val("rst_mask",      32'(cart_mask),      32'd0);
        check_val("rst_mask512",   32'(cart_mask512),   32'd0);
        check_val("rst_sz512",     32'(cart_sz512),     32'd0);
        check_val("rst_gg",        32'(gg),             32'd0);
        check_val("rst_load_done", 32'(load_done),      32'd0);
        check_val("rst_overrun",   32'(overrun),        32'd0);
        repeat (8) @(negedge clk_sys);

        // Plain 1 KB image, no header
        t_tog = toggles; t_ld = load_dones;
        run_image(8'd1, 1024, d0);
        check_val("img1k_latency",  32'(d0),                 32'd1);
        check_val("img1k_romwr_a",  32'(bus.romwr_a),        32'd1024);
        check_val("img1k_mask",     32'(cart_mask),          32'h3FF);
        check_val("img1k_mask512",  32'(cart_mask512),       32'h1FF);
        check_val("img1k_sz512",    32'(cart_sz512),         32'd0);
        check_val("img1k_gg",       32'(gg),                 32'd0);
        check_val("img1k_toggles",  32'(toggles - t_tog),    32'd1024);
        check_val("img1k_done",     32'(load_dones - t_ld),  32'd1);
        check_val("img1k_overrun",  32'(overrun),            32'd0);

        // 1 KB + 512-byte copier header
        t_tog = toggles; t_ld = load_dones;
        run_image(8'd1, 1536, d0);
        check_val("img1536_romwr_a", 32'(bus.romwr_a),       32'd1536);
        check_val("img1536_mask",    32'(cart_mask),         32'h7FF);
        check_val("img1536_mask512", 32'(cart_mask512),      32'h3FF);
        check_val("img1536_sz512",   32'(cart_sz512),        32'd1);
        check_val("img1536_toggles", 32'(toggles - t_tog),   32'd1536);
        check_val("img1536_done",    32'(load_dones - t_ld), 32'd1);

        // Game Gear image, then back to SMS
        run_image(8'd2, 64, d0);
        check_val("gg_flag",     32'(gg),           32'd1);
        check_val("gg_mask",     32'(cart_mask),    32'h3F);
        check_val("gg_mask512",  32'(cart_mask512), 32'h3FF);
        check_val("gg_sz512",    32'(cart_sz512),   32'd0);
        run_image(8'd1, 32, d0);
        check_val("sms_gg_clear", 32'(gg),          32'd0);
        check_val("sms_mask",     32'(cart_mask),   32'h1F);

        // Slow SDRAM ack
        ack_dly = 20;
        t_wait = wait_cycles; t_din = din_changes;
        start_dl(8'd1);
        for (int i = 0; i < 4; i++) begin
            send_byte(25'(i), 8'hA0 + 8'(i), d0);
            check_val("slow_rom_din", 32'(bus.rom_din), 32'(8'hA0 + 8'(i)));
        end
        end_dl();
        $display("download idx=1 bytes=4 slow ack wait_cycles=%0d", wait_cycles - t_wait);
        check_val("slow_wait_cycles", 32'(wait_cycles - t_wait), 32'd84);
        check_val("slow_din_stable",  32'(din_changes - t_din),  32'd0);
        check_val("slow_overrun",     32'(overrun),              32'd0);
        check_val("slow_mask",        32'(cart_mask),            32'h3);

        // Cheat-code download is ignored
        ack_dly = 3;
        t_tog = toggles; t_ld = load_dones; t_wait = wait_cycles;
        start_dl(8'hFF);
        check_val("code_cart_dl", 32'(cart_download), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(25'(i), 8'(i), d0);
        end_dl();
        $display("download idx=255 bytes=16 toggles=%0d", toggles - t_tog);
        check_val("code_toggles", 32'(toggles - t_tog),       32'd0);
        check_val("code_wait",    32'(wait_cycles - t_wait),  32'd0);
        check_val("code_mask",    32'(cart_mask),             32'h3);
        check_val("code_romwr_a", 32'(bus.romwr_a),           32'd4);
        check_val("code_done",    32'(load_dones - t_ld),     32'd0);

        // Reset with a write in flight, then a fresh download
        ack_dly = 10;
        start_dl(8'd1);
        bus.ioctl_addr = '0; bus.ioctl_dout = 8'h11; bus.ioctl_wr = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check_val("midrst_wait",  32'(bus.ioctl_wait),              32'd0);
        check_val("midrst_stale", 32'(bus.rom_wr != bus.rom_wack),  32'd1);
        t_tog = toggles; t_ld = load_dones;
        start_dl(8'd1);
        bus.ioctl_addr = '0; bus.ioctl_dout = 8'hC3; bus.ioctl_wr = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        check_val("hold_no_toggle", 32'(toggles - t_tog), 32'd0);
        check_val("hold_wait",      32'(bus.ioctl_wait),  32'd1);
        bus.ioctl_addr = 25'd1; bus.ioctl_dout = 8'h77; bus.ioctl_wr = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr = 1'b0;
        check_val("busy_overrun", 32'(overrun),      32'd1);
        check_val("busy_din",     32'(bus.rom_din),  32'hC3);
        begin
            int guard = 0;
            while (bus.ioctl_wait && guard < 200) begin
                @(negedge clk_sys);
                guard++;
            end
            if (guard >= 200) check_val("hold_timeout", 32'(guard), 32'd0);
        end
        check_val("hold_toggles", 32'(toggles - t_tog), 32'd1);
        check_val("hold_romwr_a", 32'(bus.romwr_a),     32'd1);
        check_val("hold_din",     32'(bus.rom_din),     32'hC3);
        end_dl();
        $display("download idx=1 bytes=1 after reset romwr_a=%0d overrun=%0d", bus.romwr_a, overrun);
        check_val("hold_done",        32'(load_dones - t_ld), 32'd1);
        check_val("hold_overrun_end", 32'(overrun),           32'd1);
        check_val("hold_mask",        32'(cart_mask),         32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
